event_capture_encoder: RTL and testbench
========================================

// Module: event_capture_encoder
// PURPOSE
//   Upstream stage of the 8-to-3 encoder path. Captures single-cycle event pulses on
//   8 lines into sticky pending bits and arbitrates among them. Emits one 3-bit code
//   per accepted transfer over a valid/ready handshake; also emits the matching one-hot.
//   Guarantees downstream only ever sees exactly one active line at a time.
// PARAMETERS
//   N   8   number of event lines (design and tests fixed at 8)
//   W   3   code width, log2(N)
// PORTS
//   clk        in   1   rising-edge clock
//   rst        in   1   synchronous, active-high reset
//   e          in   1   capture enable; evt_in ignored when 0
//   evt_in     in   8   event pulses, one bit per line, sampled every cycle
//   out_ready  in   1   downstream ready
//   ovf_clr    in   1   clears all ovf bits
//   out_valid  out  1   out_code/out_onehot hold a request
//   out_code   out  3   index of granted line
//   out_onehot out  8   1 << out_code while out_valid, else 0
//   pending    out  8   sticky pending register, not yet granted
//   ovf        out  8   sticky per-line overflow flags
// BEHAVIOUR
//   Reset (rst=1 at edge)
//     - pending=0, ovf=0, out_valid=0, out_code=0, out_onehot=0, state=IDLE.
//     - Mid-transfer reset drops the held request without handshake.
//   Capture
//     - e=1, evt_in[i]=1: pending[i] set at next edge.
//     - e=0: no capture; pending still drains.
//   Overflow
//     - evt_in[i]=1 with e=1 while pending[i]=1 and line i not loaded that cycle: ovf[i] set.
//     - ovf_clr clears all bits; a new overflow in the same cycle wins (bit stays 1).
//   Selection
//     - Fixed priority, highest index wins (0x81 -> code 7).
//   FSM IDLE / HOLD
//     - IDLE, pending!=0: load grant into out_code/out_onehot, out_valid=1, clear that
//       pending bit, go HOLD.
//     - IDLE, pending==0: stay IDLE.
//     - HOLD: outputs stable while out_ready=0.
//     - HOLD, out_valid&out_ready, pending!=0: load next grant in the same edge
//       (back-to-back, 1 transfer/cycle).
//     - HOLD, out_valid&out_ready, pending==0: out_valid=0, out_onehot=0, go IDLE;
//       out_code keeps its last value.
//   Same-cycle event and load on a line
//     - New event on the line being loaded sets pending again (new request).
//     - Not an overflow.
//   Latency
//     - evt_in high in cycle c (state IDLE, nothing pending) -> out_valid high in cycle c+2.
//   Wrap
//     - None; pending is a set, not a count. Repeats before grant collapse into ovf.
// CONFIGURATION
//   ROUND_ROBIN_EN defined
//     - Rotating priority; 3-bit pointer ptr, reset 7.
//     - Search order ptr, ptr-1, ..., wrap 0 -> 7.
//     - After granting g: ptr = (g-1) mod 8.
//     - First grant after reset matches fixed priority.
//   ROUND_ROBIN_EN undefined
//     - Fixed highest-index priority; no pointer logic.
// TESTING
//   1. rst 2 cycles -> all outputs 0.
//      Then e=1, evt_in=0x10 for 1 cycle, out_ready=1 -> out_valid in cycle c+2,
//      out_code=4, out_onehot=0x10, then out_valid=0.
//   2. evt_in=0xFF 1 cycle, out_ready=1 -> codes 7,6,5,4,3,2,1,0 on consecutive cycles;
//      no ovf.
//   3. evt_in=0x04, out_ready=0, then evt_in=0x04 again -> ovf=0x04, code 2 held stable;
//      ovf_clr -> ovf=0.
//   4. e=0, evt_in=0xFF -> pending stays 0, out_valid stays 0.
//   5. Hold code 5 with out_ready=0, pending=0x03; assert rst -> next cycle
//      out_valid=0, pending=0.
//   6. ROUND_ROBIN_EN: evt_in=0x81 repeated each grant, out_ready=1 -> codes alternate 7,0,7,0.
//      Without the macro: 7,7,7.

Source files
------------

// File: rtl/event_capture_encoder.sv
// ============================================================================
// Module     : event_capture_encoder
// Description: Captures 8 event pulses into sticky pending bits, arbitrates
//              and emits one code/one-hot per valid/ready transfer.
//              Optional macro ROUND_ROBIN_EN selects rotating priority.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module event_capture_encoder #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         e,
  input  logic [N-1:0] evt_in,
  input  logic         out_ready,
  input  logic         ovf_clr,
  output logic         out_valid,
  output logic [W-1:0] out_code,
  output logic [N-1:0] out_onehot,
  output logic [N-1:0] pending,
  output logic [N-1:0] ovf
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t       state, state_d;
  logic [N-1:0] pending_d, ovf_d, onehot_d;
  logic [N-1:0] load_mask, capture;
  logic [W-1:0] grant, code_d;
  logic         valid_d, handshake, load;

`ifdef ROUND_ROBIN_EN
  logic [W-1:0] ptr;
  logic [W-1:0] idx;
  logic         found;

  // Search downward from ptr, wrapping 0 -> N-1.
  always_comb begin
    grant = ptr;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = ptr - W'(k);
      if (!found && pending[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '1;
    end else if (load) begin
      ptr <= grant - 1'b1;
    end
  end
`else
  // Later (higher) indices overwrite earlier ones, so the highest set bit wins.
  always_comb begin
    grant = '0;
    for (int i = 0; i < N; i++) begin
      if (pending[i]) grant = W'(i);
    end
  end
`endif

  always_comb begin
    handshake = out_valid & out_ready;
    load      = ((state == IDLE) || handshake) && (pending != '0);
    load_mask = load ? (N'(1) << grant) : '0;
    capture   = e ? evt_in : '0;

    // A fresh event on the line being loaded is a new request, not an overflow.
    pending_d = (pending & ~load_mask) | capture;
    ovf_d     = (ovf_clr ? '0 : ovf) | (capture & pending & ~load_mask);

    state_d  = state;
    valid_d  = out_valid;
    code_d   = out_code;
    onehot_d = out_onehot;

    case (state)
      IDLE: begin
        if (load) state_d = HOLD;
      end
      HOLD: begin
        if (handshake && !load) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      valid_d  = 1'b1;
      code_d   = grant;
      onehot_d = load_mask;
    end else if (handshake) begin
      valid_d  = 1'b0;
      onehot_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pending    <= '0;
      ovf        <= '0;
      out_valid  <= 1'b0;
      out_code   <= '0;
      out_onehot <= '0;
    end else begin
      state      <= state_d;
      pending    <= pending_d;
      ovf        <= ovf_d;
      out_valid  <= valid_d;
      out_code   <= code_d;
      out_onehot <= onehot_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_event_capture_encoder.sv
// ============================================================================
// Module     : tb_event_capture_encoder
// Description: Scoreboard bench for event_capture_encoder (honours ROUND_ROBIN_EN).
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_event_capture_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       e = 1'b0;
  logic [7:0] evt_in = '0;
  logic       out_ready = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       out_valid;
  logic [2:0] out_code;
  logic [7:0] out_onehot;
  logic [7:0] pending;
  logic [7:0] ovf;

  int checks = 0;
  int errors = 0;

  event_capture_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .e         (e),
    .evt_in    (evt_in),
    .out_ready (out_ready),
    .ovf_clr   (ovf_clr),
    .out_valid (out_valid),
    .out_code  (out_code),
    .out_onehot(out_onehot),
    .pending   (pending),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a set of pending requests plus one held offer.
  bit   [7:0] m_pend  = '0;
  bit   [7:0] m_ovf   = '0;
  bit         m_valid = 1'b0;
  int         m_code  = 0;
  int         m_ptr   = 7;
  int         exp_q[$];
  int         seen[$];

  function automatic int pick(input bit [7:0] p, input int start);
    for (int k = 0; k < 8; k++) begin
      int j;
      j = (start - k + 8) % 8;
      if (p[j]) return j;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_pend = '0; m_ovf = '0; m_valid = 1'b0; m_code = 0; m_ptr = 7;
      exp_q.delete();
    end else begin
      bit accepted, take;
      int g;
      bit [7:0] caught;
`ifdef ROUND_ROBIN_EN
      g = pick(m_pend, m_ptr);
`else
      g = pick(m_pend, 7);
`endif
      accepted = m_valid && out_ready;
      take     = (!m_valid || accepted) && (g >= 0);
      caught   = e ? evt_in : 8'h00;
      if (ovf_clr) m_ovf = '0;
      for (int i = 0; i < 8; i++)
        if (caught[i] && m_pend[i] && !(take && g == i)) m_ovf[i] = 1'b1;
      if (take) m_pend[g] = 1'b0;
      m_pend = m_pend | caught;
      if (take) begin
        m_valid = 1'b1;
        m_code  = g;
        m_ptr   = (g + 7) % 8;
        exp_q.push_back(g);
      end else if (accepted) begin
        m_valid = 1'b0;
      end
    end
  end

  // Monitor: per-cycle state compare plus scoreboard pop on each transfer.
  always @(negedge clk) begin
    chk("valid", out_valid, m_valid);
    chk("pending", pending, m_pend);
    chk("ovf", ovf, m_ovf);
    chk("code", out_code, m_code);
    chk("onehot", out_onehot, m_valid ? (8'd1 << m_code) : 8'd0);
    if (out_valid && out_ready) begin
      seen.push_back(int'(out_code));
      if (exp_q.size() == 0) begin
        chk("sb_unexpected", 1, 0);
      end else begin
        int x;
        x = exp_q.pop_front();
        chk("sb_code", out_code, x);
        chk("sb_onehot", out_onehot, 8'd1 << x);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int exp6[4];
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_onehot", out_onehot, 0);
    chk("rst_pending", pending, 0);
    chk("rst_ovf", ovf, 0);

    // Single event: visible two cycles later.
    e = 1'b1; out_ready = 1'b1; evt_in = 8'h10;
    tick();
    evt_in = 8'h00;
    @(negedge clk);
    chk("t1_valid_c1", out_valid, 0);
    tick();
    @(negedge clk);
    chk("t1_valid_c2", out_valid, 1);
    chk("t1_code", out_code, 4);
    chk("t1_onehot", out_onehot, 8'h10);
    tick();
    @(negedge clk);
    chk("t1_valid_end", out_valid, 0);
    chk("t1_code_kept", out_code, 4);

    // All lines at once: drained highest first, one per cycle.
    seen.delete();
    evt_in = 8'hFF;
    tick();
    evt_in = 8'h00;
    tick(12);
    chk("t2_count", seen.size(), 8);
    for (int i = 0; i < 8 && i < seen.size(); i++) chk("t2_order", seen[i], 7 - i);
    chk("t2_ovf", ovf, 0);

    // Overflow while held.
    out_ready = 1'b0; evt_in = 8'h04;
    tick();
    evt_in = 8'h00;
    tick(2);
    evt_in = 8'h04;
    tick(2);
    evt_in = 8'h00;
    @(negedge clk);
    chk("t3_ovf", ovf, 8'h04);
    chk("t3_valid", out_valid, 1);
    chk("t3_code", out_code, 2);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    @(negedge clk);
    chk("t3_ovf_clr", ovf, 0);
    out_ready = 1'b1;
    tick(4);

    // Capture disabled.
    e = 1'b0; evt_in = 8'hFF;
    tick(3);
    @(negedge clk);
    chk("t4_pending", pending, 0);
    chk("t4_valid", out_valid, 0);
    e = 1'b1; evt_in = 8'h00;

    // Reset drops a held request.
    out_ready = 1'b0; evt_in = 8'h20;
    tick();
    evt_in = 8'h00;
    tick(2);
    evt_in = 8'h03;
    tick();
    evt_in = 8'h00;
    @(negedge clk);
    chk("t5_code", out_code, 5);
    chk("t5_pending", pending, 8'h03);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_valid", out_valid, 0);
    chk("t5_pend_rst", pending, 0);

    // Priority policy under continuous 0x81.
    seen.delete();
    out_ready = 1'b1; evt_in = 8'h81;
    tick(8);
    evt_in = 8'h00;
    tick(4);
`ifdef ROUND_ROBIN_EN
    exp6 = '{7, 0, 7, 0};
`else
    exp6 = '{7, 7, 7, 7};
`endif
    chk("t6_count", seen.size() >= 4, 1);
    for (int i = 0; i < 4 && i < seen.size(); i++) chk("t6_seq", seen[i], exp6[i]);
    ovf_clr = 1'b1;
    tick(12);
    ovf_clr = 1'b0;

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      e         = ($urandom % 4) != 0;
      evt_in    = 8'($urandom & $urandom & $urandom);
      out_ready = ($urandom % 3) != 0;
      ovf_clr   = ($urandom % 16) == 0;
      rst       = ($urandom % 80) == 0;
      tick();
    end
    rst = 1'b0; e = 1'b0; evt_in = 8'h00; ovf_clr = 1'b0; out_ready = 1'b1;
    tick(12);
    chk("drain_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
